// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with byte-lane write mask
// and optional zero register, write bypass, registered reads and bulk clear.
module register_file_mp #(
    parameter int REG_N                = 8,
    parameter int WIDTH                = 16,
    parameter int READ_PORTS           = 2,
    parameter int ZERO_REG             = 0,
    parameter int BYPASS               = 1,
    parameter int READ_REG             = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int AW = $clog2(REG_N),
    localparam int NL = WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       write_enabled,
    input  logic [AW-1:0]              write_addr,
    input  logic [WIDTH-1:0]           write_data,
    input  logic [NL-1:0]              write_mask,
    input  logic [READ_PORTS*AW-1:0]   read_addr,
    output logic [READ_PORTS*WIDTH-1:0] read_data,
    output logic [REG_N-1:0]           written
);

    if ((WIDTH % 8) != 0 || REG_N < 2) begin : g_param_check
        $error("register_file_mp: WIDTH must be a multiple of 8 and REG_N at least 2");
    end

    logic [WIDTH-1:0] regs [REG_N];
    logic [REG_N-1:0] written_q;
    logic             write_in_range;
    logic             write_effective;
    logic [WIDTH-1:0] write_merged;

    function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old,
                                                     input logic [WIDTH-1:0] data,
                                                     input logic [NL-1:0]    mask);
        logic [WIDTH-1:0] m;
        m = old;
        for (int k = 0; k < NL; k++) begin
            if (mask[k]) m[8*k +: 8] = data[8*k +: 8];
        end
        return m;
    endfunction

    // A write that reaches storage this edge; also the bypass qualifier.
    always_comb begin
        write_in_range  = (32'(write_addr) < REG_N);
        write_effective = reset && write_enabled && !clear && write_in_range &&
                          !(ZERO_REG != 0 && write_addr == '0);
        write_merged    = write_in_range ? merge_lanes(regs[write_addr], write_data, write_mask)
                                         : write_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < REG_N; r++) regs[r] <= RESET_VALUE;
            written_q <= '0;
        end else if (clear) begin
            for (int r = 0; r < REG_N; r++) regs[r] <= RESET_VALUE;
            written_q <= '0;
        end else if (write_effective && (write_mask != '0)) begin
            regs[write_addr]      <= write_merged;
            written_q[write_addr] <= 1'b1;
        end
    end

    // Register 0 is never stored as written, so the constant bit is ORed in here.
    assign written = written_q | REG_N'(ZERO_REG != 0);

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        logic [AW-1:0]    raddr;
        logic [WIDTH-1:0] value;

        assign raddr = read_addr[p*AW +: AW];

        always_comb begin
            value = '0;
            if (32'(raddr) >= REG_N) begin
                value = '0;
            end else if (ZERO_REG != 0 && raddr == '0) begin
                value = '0;
            end else if (BYPASS != 0 && write_effective && raddr == write_addr) begin
                value = write_merged;
            end else begin
                value = regs[raddr];
            end
        end

        if (READ_REG != 0) begin : g_registered
            logic [WIDTH-1:0] q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) q <= '0;
                else        q <= value;
            end
            assign read_data[p*WIDTH +: WIDTH] = q;
        end else begin : g_comb
            assign read_data[p*WIDTH +: WIDTH] = value;
        end
    end

endmodule
